// File: rtl/lsu.sv
// Load/store unit: one memory operation at a time, IDLE -> REQ -> RESP -> DONE.
// Optional alignment check is compiled in with the LSU_MISALIGN_CHECK_EN macro.
module lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        MemWr,
  input  logic        MemToReg,
  input  logic [2:0]  MemOp,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rdata,
  output logic        out_err,
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // the producer holds valid and its payload stable until that edge.

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]  state;
  logic        wr_q;
  logic [2:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        in_mem;
  logic        in_byte;
  logic        in_half;
  logic        in_mis;
  logic        q_byte;
  logic        q_half;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_data;

  // Reserved size codes fall through to word access.
  assign in_mem  = MemWr | MemToReg;
  assign in_byte = (MemOp[1:0] == 2'b00);
  assign in_half = (MemOp[1:0] == 2'b01);
  assign q_byte  = (op_q[1:0] == 2'b00);
  assign q_half  = (op_q[1:0] == 2'b01);

`ifdef LSU_MISALIGN_CHECK_EN
  assign in_mis = in_mem & ((in_half & addr[0]) |
                            (~in_byte & ~in_half & (addr[1:0] != 2'b00)));
`else
  assign in_mis = 1'b0;
`endif

  assign dbg_state     = state;
  assign in_ready      = (state == IDLE);
  assign mem_req_valid = (state == REQ);
  assign out_valid     = (state == DONE);
  assign mem_addr      = {addr_q[31:2], 2'b00};
  assign mem_wen       = wr_q;
  assign out_rdata     = rdata_q;
  assign out_err       = err_q;

  always_comb begin
    mem_wmask = 4'b0000;
    mem_wdata = wdata_q;
    if (q_byte) begin
      mem_wdata = {4{wdata_q[7:0]}};
      if (wr_q) mem_wmask = 4'b0001 << addr_q[1:0];
    end else if (q_half) begin
      mem_wdata = {2{wdata_q[15:0]}};
      if (wr_q) mem_wmask = 4'b0011 << {addr_q[1], 1'b0};
    end else begin
      if (wr_q) mem_wmask = 4'b1111;
    end
  end

  always_comb begin
    lane_b = mem_rdata[7:0];
    case (addr_q[1:0])
      2'd1:    lane_b = mem_rdata[15:8];
      2'd2:    lane_b = mem_rdata[23:16];
      2'd3:    lane_b = mem_rdata[31:24];
      default: lane_b = mem_rdata[7:0];
    endcase
    lane_h = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    if (q_byte)
      load_data = op_q[2] ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
    else if (q_half)
      load_data = op_q[2] ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
    else
      load_data = mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      wr_q    <= 1'b0;
      op_q    <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            wr_q    <= MemWr;
            op_q    <= MemOp;
            addr_q  <= addr;
            wdata_q <= wdata;
            rdata_q <= 32'd0;
            err_q   <= in_mis;
            // No-ops and misaligned accesses complete without touching the bus.
            state   <= (in_mem && !in_mis) ? REQ : DONE;
          end
        end
        REQ: begin
          if (mem_req_ready) state <= RESP;
        end
        RESP: begin
          if (mem_resp_valid) begin
            rdata_q <= wr_q ? 32'd0 : load_data;
            state   <= DONE;
          end
        end
        default: begin
          if (out_ready) state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed cases plus randomized traffic checked
// by a queue-based scoreboard fed from a size/offset reference model.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        MemWr;
  logic        MemToReg;
  logic [2:0]  MemOp;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rdata;
  logic        out_err;
  logic [1:0]  dbg_state;

  lsu dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .MemWr(MemWr), .MemToReg(MemToReg), .MemOp(MemOp), .addr(addr), .wdata(wdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
    .out_err(out_err), .dbg_state(dbg_state)
  );

`ifdef LSU_MISALIGN_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, expected finish within 40000 cycles");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [32:0] exp_q[$];       // {err, rdata} per result
  int          exp_lat_q[$];   // expected latency, -1 = not checked
  logic [68:0] req_q[$];       // {addr, wen, wmask, wdata} per bus request
  bit          req_store_q[$];
  logic [31:0] resp_q[$];      // bus read data to return per request
  int hs_count = 0, issued_mem = 0, accept_cyc = 0;
  bit rand_mode = 1'b0;
  int req_stall_left = 0, out_stall_left = 0, resp_fixed = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int op_size(input logic [2:0] op);
    case (op)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic bit op_signed(input logic [2:0] op);
    return (op == 3'b000) || (op == 3'b001);
  endfunction

  function automatic int field_off(input logic [2:0] op, input logic [31:0] a);
    int n = op_size(op);
    return (int'(a[1:0]) / n) * n;
  endfunction

  function automatic bit model_mis(input logic [2:0] op, input logic [31:0] a);
    return (int'(a[1:0]) % op_size(op)) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] rd);
    int n = op_size(op);
    longint unsigned span = 64'd1 << (8 * n);
    longint unsigned v = ({32'd0, rd} >> (8 * field_off(op, a))) & (span - 1);
    if (n < 4 && op_signed(op) && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  function automatic logic [3:0] model_mask(input logic [2:0] op, input logic [31:0] a);
    int n = op_size(op);
    int m = ((1 << n) - 1) << field_off(op, a);
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] op, input logic [31:0] wd);
    int n = op_size(op);
    longint unsigned span = 64'd1 << (8 * n);
    longint unsigned r = ({32'd0, wd} & (span - 1)) * (64'hFFFF_FFFF / (span - 1));
    return r[31:0];
  endfunction

  // ---------------- driver ----------------
  task automatic issue(input bit wr, input bit rd, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                       input int lat, input bit expect_out);
    bit mem = wr | rd;
    bit mis = CHECK_EN && mem && model_mis(op, a);
    int waited = 0;
    if (mem && !mis) begin
      req_q.push_back({a & 32'hFFFF_FFFC, wr, (wr ? model_mask(op, a) : 4'b0000),
                       model_wdata(op, wd)});
      req_store_q.push_back(wr);
      resp_q.push_back(rdat);
      issued_mem++;
    end
    if (expect_out) begin
      exp_q.push_back({mis, ((!mem || mis || wr) ? 32'd0 : model_load(op, a, rdat))});
      exp_lat_q.push_back(lat);
    end
    @(negedge clk);
    while (!in_ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'(in_ready), 32'd1);
      return;
    end
    in_valid = 1'b1; MemWr = wr; MemToReg = rd; MemOp = op; addr = a; wdata = wd;
    @(posedge clk);
    #1;
    accept_cyc = cyc;
    // Scramble the inputs so anything not latched at accept shows up as an error.
    in_valid = 1'b0; MemWr = 1'($urandom); MemToReg = 1'($urandom);
    MemOp = 3'($urandom); addr = $urandom; wdata = $urandom;
  endtask

  task automatic wait_idle();
    int waited = 0;
    while ((exp_q.size() != 0 || req_q.size() != 0 || !in_ready) && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 500) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- bus model + request monitor ----------------
  bit          resp_pending = 1'b0;
  int          resp_wait = 0;
  logic [31:0] resp_data = '0;
  bit          req_hold = 1'b0;
  logic [68:0] req_held = '0;

  initial begin
    logic [68:0] e;
    bit st;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_resp_valid = 1'b0;
      mem_rdata = $urandom;
      if (resp_pending) begin
        if (resp_wait == 0) begin
          mem_resp_valid = 1'b1; mem_rdata = resp_data; resp_pending = 1'b0;
        end else resp_wait--;
      end
      if (req_hold) begin
        chk("req_valid_held", 32'(mem_req_valid), 32'd1);
        chk("req_addr_stable", mem_addr, req_held[68:37]);
        chk("req_wen_mask_stable", 32'({mem_wen, mem_wmask}), 32'(req_held[36:32]));
        chk("req_wdata_stable", mem_wdata, req_held[31:0]);
      end
      if (mem_req_valid) chk("in_ready_low_in_req", 32'(in_ready), 32'd0);
      if (mem_req_valid && req_stall_left > 0) begin
        mem_req_ready = 1'b0;
        req_stall_left--;
      end else if (rand_mode) mem_req_ready = ($urandom_range(0, 2) != 0);
      else mem_req_ready = 1'b1;
      if (mem_req_valid && mem_req_ready) begin
        hs_count++;
        if (req_q.size() == 0) begin
          chk("unexpected_bus_req", 32'd1, 32'd0);
        end else begin
          e  = req_q.pop_front();
          st = req_store_q.pop_front();
          chk("mem_addr", mem_addr, e[68:37]);
          chk("mem_wen", 32'(mem_wen), 32'(e[36]));
          chk("mem_wmask", 32'(mem_wmask), 32'(e[35:32]));
          if (st) chk("mem_wdata", mem_wdata, e[31:0]);
        end
        resp_data = (resp_q.size() != 0) ? resp_q.pop_front() : $urandom;
        resp_pending = 1'b1;
        resp_wait = (resp_fixed >= 0) ? resp_fixed : (rand_mode ? $urandom_range(0, 3) : 0);
        req_hold = 1'b0;
      end else if (mem_req_valid) begin
        req_hold = 1'b1;
        req_held = {mem_addr, mem_wen, mem_wmask, mem_wdata};
      end else req_hold = 1'b0;
    end
  end

  // ---------------- result monitor ----------------
  initial begin
    logic [32:0] e;
    int lat_e;
    int first_valid = -1;
    bit out_hold = 1'b0;
    logic [32:0] out_held = '0;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid) begin
        if (first_valid < 0) first_valid = cyc;
        chk("in_ready_low_in_done", 32'(in_ready), 32'd0);
        if (out_hold) begin
          chk("out_rdata_stable", out_rdata, out_held[31:0]);
          chk("out_err_stable", 32'(out_err), 32'(out_held[32]));
        end
      end else if (out_hold) chk("out_valid_held", 32'(out_valid), 32'd1);
      if (out_valid && out_stall_left > 0) begin
        out_ready = 1'b0;
        out_stall_left--;
      end else out_ready = rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          lat_e = exp_lat_q.pop_front();
          chk("out_rdata", out_rdata, e[31:0]);
          chk("out_err", 32'(out_err), 32'(e[32]));
          if (lat_e >= 0) chk("latency", 32'(first_valid - accept_cyc + 1), 32'(lat_e));
        end
        first_valid = -1;
        out_hold = 1'b0;
      end else if (out_valid) begin
        out_hold = 1'b1;
        out_held = {out_err, out_rdata};
      end else out_hold = 1'b0;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int h0;
    int r;
    logic [2:0] op;
    rst = 1'b1; in_valid = 1'b0; MemWr = 1'b0; MemToReg = 1'b0; MemOp = '0;
    addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_mem_wen", 32'(mem_wen), 32'd0);
    chk("rst_mem_wmask", 32'(mem_wmask), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_rdata", out_rdata, 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    rst = 1'b0;

    // Directed cases on a zero-wait bus.
    issue(1'b0, 1'b1, 3'b010, 32'h8000_0004, $urandom, 32'hDEAD_BEEF, 3, 1'b1);
    issue(1'b0, 1'b1, 3'b000, 32'h8000_0003, $urandom, 32'h80FF_1234, 3, 1'b1);
    issue(1'b0, 1'b1, 3'b100, 32'h8000_0003, $urandom, 32'h80FF_1234, 3, 1'b1);
    issue(1'b1, 1'b0, 3'b001, 32'h8000_0002, 32'h0000_ABCD, $urandom, 3, 1'b1);
    issue(1'b0, 1'b1, 3'b101, 32'h8000_0002, $urandom, 32'h9876_5432, 3, 1'b1);
    issue(1'b0, 1'b1, 3'b001, 32'h8000_0000, $urandom, 32'h1234_8001, 3, 1'b1);
    issue(1'b0, 1'b1, 3'b011, 32'h8000_0008, $urandom, 32'h0BAD_F00D, 3, 1'b1);
    issue(1'b1, 1'b0, 3'b111, 32'h8000_000C, 32'h1122_3344, $urandom, 3, 1'b1);
    issue(1'b1, 1'b1, 3'b000, 32'h8000_0001, 32'h0000_00A5, 32'hFFFF_FFFF, 3, 1'b1);
    issue(1'b0, 1'b0, 3'b010, 32'h8000_0000, $urandom, $urandom, 1, 1'b1);
    issue(1'b0, 1'b1, 3'b010, 32'h8000_0001, $urandom, 32'hCAFE_F00D,
          (CHECK_EN ? 1 : 3), 1'b1);
    issue(1'b1, 1'b0, 3'b001, 32'h8000_0003, 32'h0000_5A5A, $urandom,
          (CHECK_EN ? 1 : 3), 1'b1);
    wait_idle();

    // Backpressure: 4 stalled request cycles, 2 stalled result cycles.
    h0 = hs_count;
    req_stall_left = 4;
    out_stall_left = 2;
    issue(1'b1, 1'b0, 3'b010, 32'h8000_0010, 32'h1234_5678, $urandom, 7, 1'b1);
    wait_idle();
    chk("one_bus_request", 32'(hs_count - h0), 32'd1);
    chk("req_stall_used", 32'(req_stall_left), 32'd0);
    chk("out_stall_used", 32'(out_stall_left), 32'd0);

    // Reset while waiting for the bus response; the late response must be ignored.
    resp_fixed = 3;
    h0 = hs_count;
    issue(1'b0, 1'b1, 3'b010, 32'h8000_0020, $urandom, 32'h1111_1111, -1, 1'b0);
    r = 0;
    while (hs_count == h0 && r < 50) begin
      @(negedge clk);
      r++;
    end
    chk("rst_test_handshake", 32'(hs_count - h0), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_resp_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      chk("rst_resp_out_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
    end
    resp_fixed = -1;

    // Randomized traffic with random bus and writeback backpressure.
    rand_mode = 1'b1;
    for (int i = 0; i < 80; i++) begin
      r  = $urandom_range(0, 9);
      op = 3'($urandom);
      issue((r >= 5 && r <= 8) || r == 9, (r <= 4) || r == 9, op,
            32'h8000_0000 | ($urandom & 32'hFF), $urandom, $urandom, -1, 1'b1);
    end
    wait_idle();
    rand_mode = 1'b0;
    repeat (4) @(negedge clk);

    chk("req_queue_empty", 32'(req_q.size()), 32'd0);
    chk("exp_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("bus_request_count", 32'(hs_count), 32'(issued_mem));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
